// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: load-use bubbles, branch/jump flushes
// and fixed-latency EX freezes. Define PERF_CNT_EN to build the stall/flush counters.
module pipeline_hazard_ctrl #(
  parameter int LONG_LAT = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             memread_idex,
  input  logic [4:0]       rd_idex,
  input  logic [4:0]       rs_ifid,
  input  logic [4:0]       rt_ifid,
  input  logic             uses_rt_id,
  input  logic             branch_taken_ex,
  input  logic             jump_id,
  input  logic             long_op_ex,
  output logic             PCWrite,
  output logic             Write_IFID,
  output logic             Write_IDEX,
  output logic             flush_IFID,
  output logic             flush_IDEX,
  output logic             flush_EXMEM,
  output logic             long_done,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic {RUN, LONG} state_e;

  localparam bit         LongEn   = (LONG_LAT >= 2);
  localparam logic [3:0] LongInit = LongEn ? 4'(LONG_LAT - 2) : 4'd0;

  state_e     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       lu;

  assign lu = memread_idex && (rd_idex != 5'd0) &&
              ((rd_idex == rs_ifid) || (uses_rt_id && (rd_idex == rt_ifid)));

  always_comb begin
    PCWrite     = 1'b1;
    Write_IFID  = 1'b1;
    Write_IDEX  = 1'b1;
    flush_IFID  = 1'b0;
    flush_IDEX  = 1'b0;
    flush_EXMEM = 1'b0;
    long_done   = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    if (rst) begin
      PCWrite     = 1'b0;
      Write_IFID  = 1'b0;
      Write_IDEX  = 1'b0;
      flush_IFID  = 1'b1;
      flush_IDEX  = 1'b1;
      flush_EXMEM = 1'b1;
      state_d     = RUN;
      cnt_d       = 4'd0;
    end else begin
      case (state_q)
        RUN: begin
          if (branch_taken_ex) begin
            flush_IFID = 1'b1;
            flush_IDEX = 1'b1;
          end else if (long_op_ex && LongEn) begin
            PCWrite     = 1'b0;
            Write_IFID  = 1'b0;
            Write_IDEX  = 1'b0;
            flush_EXMEM = 1'b1;
            state_d     = LONG;
            cnt_d       = LongInit;
          end else if (lu) begin
            PCWrite    = 1'b0;
            Write_IFID = 1'b0;
            flush_IDEX = 1'b1;
          end else if (jump_id) begin
            flush_IFID = 1'b1;
          end
        end
        LONG: begin
          // Front-end hazards are held off until the long op leaves EX.
          if (cnt_q != 4'd0) begin
            PCWrite     = 1'b0;
            Write_IFID  = 1'b0;
            Write_IDEX  = 1'b0;
            flush_EXMEM = 1'b1;
            cnt_d       = cnt_q - 4'd1;
          end else begin
            long_done = 1'b1;
            state_d   = RUN;
          end
        end
        default: state_d = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q   <= cnt_d;
  end

`ifdef PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (!PCWrite && !(&stall_cnt_q)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (flush_IFID && !(&flush_cnt_q)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (LONG_LAT=4, CNT_W=16); one vector per clock cycle.
// Counter checks follow PERF_CNT_EN the same way as the design build.
module tb_pipeline_hazard_ctrl;

  logic        clk, rst;
  logic        memread_idex, uses_rt_id, branch_taken_ex, jump_id, long_op_ex;
  logic [4:0]  rd_idex, rs_ifid, rt_ifid;
  logic        PCWrite, Write_IFID, Write_IDEX, flush_IFID, flush_IDEX, flush_EXMEM, long_done;
  logic [15:0] stall_cnt, flush_cnt;

  pipeline_hazard_ctrl #(.LONG_LAT(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .memread_idex(memread_idex), .rd_idex(rd_idex), .rs_ifid(rs_ifid), .rt_ifid(rt_ifid),
    .uses_rt_id(uses_rt_id), .branch_taken_ex(branch_taken_ex), .jump_id(jump_id),
    .long_op_ex(long_op_ex),
    .PCWrite(PCWrite), .Write_IFID(Write_IFID), .Write_IDEX(Write_IDEX),
    .flush_IFID(flush_IFID), .flush_IDEX(flush_IDEX), .flush_EXMEM(flush_EXMEM),
    .long_done(long_done), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {PCWrite, Write_IFID, Write_IDEX, flush_IFID, flush_IDEX, flush_EXMEM, long_done}
  localparam logic [6:0] O_DEF = 7'b1110000;
  localparam logic [6:0] O_RST = 7'b0001110;
  localparam logic [6:0] O_LU  = 7'b0010100;
  localparam logic [6:0] O_BR  = 7'b1111100;
  localparam logic [6:0] O_JMP = 7'b1111000;
  localparam logic [6:0] O_FRZ = 7'b0000010;
  localparam logic [6:0] O_DON = 7'b1110001;

  typedef struct {
    logic       rst, mr;
    logic [4:0] rd, rs, rt;
    logic       urt, br, jmp, lng;
    logic [6:0] exp;
    string      name;
  } vec_t;

  int pass_cnt = 0;
  int total    = 0;
  int exp_stall = 0;
  int exp_flush = 0;
  logic [6:0] outs;

  assign outs = {PCWrite, Write_IFID, Write_IDEX, flush_IFID, flush_IDEX, flush_EXMEM, long_done};

  function automatic vec_t mk(input logic r, input logic mr, input logic [4:0] rd,
                              input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                              input logic br, input logic jmp, input logic lng,
                              input logic [6:0] exp, input string name);
    vec_t v;
    v.rst = r; v.mr = mr; v.rd = rd; v.rs = rs; v.rt = rt; v.urt = urt;
    v.br = br; v.jmp = jmp; v.lng = lng; v.exp = exp; v.name = name;
    return v;
  endfunction

  task automatic check_val(input string name, input int act, input int req);
    total++;
    if (act == req) pass_cnt++;
    else $display("FAIL %s: got %0d, required %0d", name, act, req);
  endtask

  task automatic apply(input vec_t v);
    int req_s, req_f;
    rst = v.rst; memread_idex = v.mr; rd_idex = v.rd; rs_ifid = v.rs; rt_ifid = v.rt;
    uses_rt_id = v.urt; branch_taken_ex = v.br; jump_id = v.jmp; long_op_ex = v.lng;
    @(negedge clk);
    total++;
    if (outs === v.exp) pass_cnt++;
    else $display("FAIL %s: outputs %b, required %b", v.name, outs, v.exp);
`ifdef PERF_CNT_EN
    req_s = exp_stall;
    req_f = exp_flush;
`else
    req_s = 0;
    req_f = 0;
`endif
    check_val({v.name, "/stall_cnt"}, int'(stall_cnt), req_s);
    check_val({v.name, "/flush_cnt"}, int'(flush_cnt), req_f);
    if (v.rst) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (!v.exp[6] && exp_stall < 65535) exp_stall++;
      if (v.exp[3] && exp_flush < 65535) exp_flush++;
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[12];

  initial begin
    rst = 1'b1; memread_idex = 1'b0; rd_idex = '0; rs_ifid = '0; rt_ifid = '0;
    uses_rt_id = 1'b0; branch_taken_ex = 1'b0; jump_id = 1'b0; long_op_ex = 1'b0;

    //           rst mr rd     rs     rt     urt br jmp lng exp
    tbl[0]  = mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_RST, "reset_0");
    tbl[1]  = mk(1, 1, 5'd5, 5'd5, 5'd0, 0, 1, 1, 1, O_RST, "reset_1_inputs_active");
    tbl[2]  = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_DEF, "first_run_cycle");
    tbl[3]  = mk(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, O_LU,  "loaduse_rs");
    tbl[4]  = mk(0, 1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, O_DEF, "loaduse_rd0");
    tbl[5]  = mk(0, 1, 5'd7, 5'd1, 5'd7, 0, 0, 0, 0, O_DEF, "rt_match_no_use");
    tbl[6]  = mk(0, 1, 5'd7, 5'd1, 5'd7, 1, 0, 0, 0, O_LU,  "loaduse_rt");
    tbl[7]  = mk(0, 0, 5'd5, 5'd5, 5'd5, 1, 0, 0, 0, O_DEF, "no_load_match");
    tbl[8]  = mk(0, 1, 5'd9, 5'd9, 5'd0, 0, 1, 1, 0, O_BR,  "branch_over_lu_jump");
    tbl[9]  = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, O_JMP, "jump_only");
    tbl[10] = mk(0, 1, 5'd3, 5'd3, 5'd0, 0, 0, 1, 0, O_LU,  "lu_over_jump");
    tbl[11] = mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, O_BR,  "branch_only");

    @(posedge clk);
    #1;
    for (int i = 0; i < 12; i++) apply(tbl[i]);

    // Long op with branch/lu noise while frozen, then a back-to-back restart.
    apply(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_RST, "pre_long_reset"));
    apply(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, O_FRZ, "long_frz1"));
    apply(mk(0, 1, 5'd4, 5'd4, 5'd0, 0, 1, 0, 1, O_FRZ, "long_frz2_ignore"));
    apply(mk(0, 1, 5'd4, 5'd4, 5'd0, 0, 1, 1, 1, O_FRZ, "long_frz3_ignore"));
    apply(mk(0, 1, 5'd4, 5'd4, 5'd0, 0, 1, 1, 1, O_DON, "long_done"));
    apply(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, O_FRZ, "long2_frz1"));
    apply(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, O_FRZ, "long2_frz2"));
    apply(mk(1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, O_RST, "long2_reset_mid"));
    apply(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_DEF, "after_reset_run"));
    apply(mk(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, O_DEF, "no_late_done"));
    apply(mk(0, 1, 5'd6, 5'd6, 5'd0, 0, 0, 0, 0, O_LU,  "run_after_long_lu"));

`ifdef PERF_CNT_EN
    rst = 1'b0; memread_idex = 1'b1; rd_idex = 5'd5; rs_ifid = 5'd5;
    uses_rt_id = 1'b0; branch_taken_ex = 1'b0; jump_id = 1'b0; long_op_ex = 1'b0;
    repeat (70000) @(posedge clk);
    #1;
    exp_stall = (exp_stall + 70000 > 65535) ? 65535 : exp_stall + 70000;
    apply(mk(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, O_LU, "stall_sat"));
    apply(mk(0, 1, 5'd5, 5'd5, 5'd0, 0, 0, 0, 0, O_LU, "stall_sat_hold"));
    check_val("stall_cnt_all_ones", int'(stall_cnt), 65535);
`endif

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
